// File: rtl/credential_entry_ctrl_pkg.sv
// credential_entry_ctrl_pkg: shared state encodings, buffer geometry and nibble index mapping
package credential_entry_ctrl_pkg;
  typedef enum logic [1:0] {ENTRY = 2'd0, FLAG_HOLD = 2'd1, LOCKOUT = 2'd2, RESOLVE = 2'd3} state_e;
  localparam int MAX_DIGITS = 8;
  localparam int NIBBLE_W = 4;
  localparam int USER_BASE = 0;
  localparam int PASS_BASE = 4;
endpackage

// File: rtl/credential_entry_ctrl_if.sv
// credential_entry_ctrl_if: button/checker inputs and credential/status outputs of the entry controller
interface credential_entry_ctrl_if;
  logic [3:0] digit_in;
  logic enter_pulse;
  logic back_pulse;
  logic clear_pulse;
  logic reset_count;
  logic flag;
  logic flag_select;
  logic [3:0] input_count;
  logic [15:0] user_name;
  logic [15:0] password;
  logic flag_resolve;
  logic locked_out;
  logic [1:0] state;
  modport master (
    output digit_in, enter_pulse, back_pulse, clear_pulse, reset_count, flag, flag_select,
    input input_count, user_name, password, flag_resolve, locked_out, state
  );
  modport slave (
    input digit_in, enter_pulse, back_pulse, clear_pulse, reset_count, flag, flag_select,
    output input_count, user_name, password, flag_resolve, locked_out, state
  );
endinterface

// File: rtl/credential_digit_buffer.sv
// credential_digit_buffer: eight-nibble entry buffer with clear > backspace > append priority
module credential_digit_buffer
  import credential_entry_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic back,
  input  logic enter,
  input  logic [NIBBLE_W-1:0] digit,
  output logic [3:0] count,
  output logic [15:0] user_name,
  output logic [15:0] password
);
  logic [MAX_DIGITS-1:0][NIBBLE_W-1:0] buf_q, buf_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] last_idx;
  assign last_idx = 3'(cnt_q - 4'd1);
  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    if (clr) begin
      buf_d = '0;
      cnt_d = '0;
    end else if (back) begin
      if (cnt_q != '0) begin
        buf_d[last_idx] = '0;
        cnt_d = cnt_q - 4'd1;
      end
    end else if (enter && cnt_q != 4'(MAX_DIGITS)) begin
      buf_d[cnt_q[2:0]] = digit;
      cnt_d = cnt_q + 4'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  assign count = cnt_q;
  assign user_name = buf_q[USER_BASE+3:USER_BASE];
  assign password = buf_q[PASS_BASE+3:PASS_BASE];
endmodule

// File: rtl/credential_entry_ctrl.sv
// credential_entry_ctrl: digit entry sequencer with failed-login flag hold, lockout and resolve handshake
module credential_entry_ctrl
  import credential_entry_ctrl_pkg::*;
#(
  parameter int FLAG_HOLD_CYCLES = 50_000_000,
  parameter int LOCKOUT_CYCLES = 500_000_000,
  parameter int TIMER_W = 32
) (
  input logic clk,
  input logic rst_n,
  credential_entry_ctrl_if.slave bus
);
  localparam logic [TIMER_W-1:0] FLAG_T = TIMER_W'(FLAG_HOLD_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCK_T = TIMER_W'(LOCKOUT_CYCLES - 1);
  state_e state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic rc_q;
  logic rc_rise, clr, back, enter;
  assign rc_rise = bus.reset_count & ~rc_q;
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    clr = rc_rise;
    back = 1'b0;
    enter = 1'b0;
    case (state_q)
      ENTRY: begin
        if (bus.flag) begin
          state_d = bus.flag_select ? LOCKOUT : FLAG_HOLD;
          timer_d = bus.flag_select ? LOCK_T : FLAG_T;
          clr = 1'b1;
        end else begin
          clr = rc_rise | bus.clear_pulse;
          back = bus.back_pulse;
          enter = bus.enter_pulse;
        end
      end
      FLAG_HOLD, LOCKOUT: begin
        if (timer_q == '0) state_d = RESOLVE;
        else timer_d = timer_q - TIMER_W'(1);
      end
      RESOLVE: state_d = bus.flag ? RESOLVE : ENTRY;
      default: state_d = ENTRY;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ENTRY;
      timer_q <= '0;
      rc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      rc_q <= bus.reset_count;
    end
  credential_digit_buffer u_buf (
    .clk(clk),
    .rst_n(rst_n),
    .clr(clr),
    .back(back),
    .enter(enter),
    .digit(bus.digit_in),
    .count(bus.input_count),
    .user_name(bus.user_name),
    .password(bus.password)
  );
  assign bus.state = state_q;
  assign bus.flag_resolve = state_q == RESOLVE;
  assign bus.locked_out = state_q == LOCKOUT;
endmodule

// File: tb/tb_credential_entry_ctrl.sv
// tb_credential_entry_ctrl: directed scoreboard bench for credential_entry_ctrl
module tb_credential_entry_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  credential_entry_ctrl_if bus ();
  credential_entry_ctrl #(.FLAG_HOLD_CYCLES(4), .LOCKOUT_CYCLES(6), .TIMER_W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  typedef struct {string tag; logic [39:0] v;} exp_t;
  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  logic [3:0] m_d[8];
  int m_cnt, m_st, m_t;
  logic m_rc;
  int lk, rs;
  function automatic logic [39:0] model_v();
    return {4'(m_cnt), m_d[3], m_d[2], m_d[1], m_d[0], m_d[7], m_d[6], m_d[5], m_d[4],
            2'(m_st), m_st == 3, m_st == 2};
  endfunction
  function automatic logic [39:0] obs();
    return {bus.input_count, bus.user_name, bus.password, bus.state, bus.flag_resolve, bus.locked_out};
  endfunction
  task automatic chk(string tag, logic [39:0] o, logic [39:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  task automatic m_clear();
    for (int i = 0; i < 8; i++) m_d[i] = 4'd0;
    m_cnt = 0;
  endtask
  task automatic m_reset();
    m_clear();
    m_st = 0;
    m_t = 0;
    m_rc = 1'b0;
  endtask
  task automatic cyc(string tag, logic [3:0] d, logic en, logic bk, logic cl, logic rc, logic fl, logic fs);
    exp_t e;
    logic rise;
    @(negedge clk);
    bus.digit_in = d;
    bus.enter_pulse = en;
    bus.back_pulse = bk;
    bus.clear_pulse = cl;
    bus.reset_count = rc;
    bus.flag = fl;
    bus.flag_select = fs;
    rise = rc & ~m_rc;
    m_rc = rc;
    case (m_st)
      0: if (fl) begin
        m_clear();
        m_st = fs ? 2 : 1;
        m_t = fs ? 5 : 3;
      end else if (rise || cl) m_clear();
      else if (bk) begin
        if (m_cnt > 0) begin
          m_cnt--;
          m_d[m_cnt] = 4'd0;
        end
      end else if (en && m_cnt < 8) begin
        m_d[m_cnt] = d;
        m_cnt++;
      end
      1, 2: begin
        if (rise) m_clear();
        if (m_t == 0) m_st = 3;
        else m_t--;
      end
      default: begin
        if (rise) m_clear();
        if (!fl) m_st = 0;
      end
    endcase
    sb.push_back('{tag, model_v()});
    @(posedge clk);
    #1;
    if (sb.size() == 0) chk("sb_empty", 40'd0, 40'd1);
    else begin
      e = sb.pop_front();
      chk(e.tag, obs(), e.v);
    end
  endtask
  initial begin
    bus.digit_in = '0;
    bus.enter_pulse = 1'b0;
    bus.back_pulse = 1'b0;
    bus.clear_pulse = 1'b0;
    bus.reset_count = 1'b0;
    bus.flag = 1'b0;
    bus.flag_select = 1'b0;
    m_reset();
    #12;
    chk("reset", obs(), 40'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc("e1", 4'd1, 1, 0, 0, 0, 0, 0);
    cyc("e2", 4'd1, 1, 0, 0, 0, 0, 0);
    cyc("e3", 4'd0, 1, 0, 0, 0, 0, 0);
    cyc("e4", 4'd0, 1, 0, 0, 0, 0, 0);
    cyc("e5", 4'd1, 1, 0, 0, 0, 0, 0);
    cyc("e6", 4'd1, 1, 0, 0, 0, 0, 0);
    cyc("e7", 4'd0, 1, 0, 0, 0, 0, 0);
    cyc("e8", 4'd0, 1, 0, 0, 0, 0, 0);
    chk("full8", obs(), {4'd8, 16'h0011, 16'h0011, 4'd0});
    cyc("e9_ignored", 4'd7, 1, 0, 0, 0, 0, 0);
    chk("full8_hold", obs(), {4'd8, 16'h0011, 16'h0011, 4'd0});
    cyc("clr", 4'd0, 0, 0, 1, 0, 0, 0);
    cyc("d3", 4'd3, 1, 0, 0, 0, 0, 0);
    cyc("d5", 4'd5, 1, 0, 0, 0, 0, 0);
    cyc("d9", 4'd9, 1, 0, 0, 0, 0, 0);
    cyc("bk", 4'd0, 0, 1, 0, 0, 0, 0);
    cyc("d2", 4'd2, 1, 0, 0, 0, 0, 0);
    chk("bksp", obs(), {4'd3, 16'h0253, 16'h0000, 4'd0});
    cyc("clr2", 4'd0, 0, 0, 1, 0, 0, 0);
    cyc("bk_at0", 4'd0, 0, 1, 0, 0, 0, 0);
    chk("bk_at0_cnt", 40'(bus.input_count), 40'd0);
    cyc("d4", 4'd4, 1, 0, 0, 0, 0, 0);
    cyc("d5b", 4'd5, 1, 0, 0, 0, 0, 0);
    cyc("en_bk", 4'd6, 1, 1, 0, 0, 0, 0);
    chk("bk_wins", obs(), {4'd1, 16'h0004, 16'h0000, 4'd0});
    cyc("rc1", 4'd0, 0, 0, 0, 1, 0, 0);
    cyc("rc2_en", 4'd7, 1, 0, 0, 1, 0, 0);
    cyc("rc3", 4'd0, 0, 0, 0, 1, 0, 0);
    cyc("rc4", 4'd0, 0, 0, 0, 1, 0, 0);
    cyc("rc5", 4'd0, 0, 0, 0, 1, 0, 0);
    cyc("rc_off_en", 4'd8, 1, 0, 0, 0, 0, 0);
    chk("rc_single", obs(), {4'd2, 16'h0087, 16'h0000, 4'd0});
    cyc("fh_go", 4'd0, 0, 0, 0, 0, 1, 0);
    chk("fh_state", 40'(bus.state), 40'd1);
    cyc("fh1", 4'd1, 1, 0, 0, 0, 1, 0);
    cyc("fh2", 4'd0, 0, 1, 0, 0, 1, 0);
    cyc("fh3", 4'd0, 0, 0, 1, 0, 1, 0);
    chk("fh_no_resolve", 40'(bus.flag_resolve), 40'd0);
    cyc("fh4", 4'd0, 0, 0, 0, 0, 1, 0);
    chk("fh_resolve", 40'(bus.flag_resolve), 40'd1);
    cyc("rs_hold", 4'd0, 0, 0, 0, 0, 1, 0);
    cyc("rs_drop", 4'd0, 0, 0, 0, 0, 0, 0);
    chk("rs_exit", obs(), 40'd0);
    cyc("lk_go", 4'd3, 1, 0, 0, 0, 1, 1);
    lk = int'(bus.locked_out);
    rs = 0;
    for (int i = 0; i < 9; i++) begin
      cyc("lk_run", 4'(i), 1, 0, 0, 0, 0, 0);
      lk += int'(bus.locked_out);
      rs += int'(bus.flag_resolve);
    end
    chk("lk_cycles", 40'(lk), 40'd6);
    chk("lk_resolve", 40'(rs), 40'd1);
    chk("lk_after", 40'(bus.input_count), 40'd2);
    cyc("lk2_go", 4'd0, 0, 0, 0, 0, 1, 1);
    cyc("lk2_a", 4'd0, 0, 0, 0, 0, 1, 1);
    cyc("lk2_b", 4'd0, 0, 0, 0, 0, 1, 1);
    chk("lk2_locked", 40'(bus.locked_out), 40'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("async_rst", obs(), model_v());
    chk("async_rst_lock", 40'(bus.locked_out), 40'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.flag = 1'b0;
    cyc("post_rst", 4'd5, 1, 0, 0, 0, 0, 0);
    chk("post_rst_cnt", obs(), {4'd1, 16'h0005, 16'h0000, 4'd0});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
